// File: rtl/mult_sched_pkg.sv
// Shared types, constants and the round-robin search helper for the
// multiplier scheduler.
package mult_sched_pkg;

  // Default configuration of the scheduler.
  localparam int MS_NREQ  = 4;
  localparam int MS_WIDTH = 8;
  localparam int ID_W     = $clog2(MS_NREQ);

  // Widest requester set the search helper handles, and its index width.
  localparam int NREQ_MAX = 8;
  localparam int PICK_W   = 3;

  // One operand-stage entry in the default configuration.
  typedef struct packed {
    logic [MS_WIDTH-1:0] m;
    logic [MS_WIDTH-1:0] q;
    logic [ID_W-1:0]     id;
  } op_t;

  // Round-robin search: start at ptr+1 (mod nreq) and return the first
  // requester with its valid bit set.
  // Result layout: {found, idx}.
  // Bits of valid at or above nreq are ignored.
  function automatic logic [PICK_W:0] rr_pick(input logic [NREQ_MAX-1:0] valid,
                                              input logic [PICK_W-1:0]   ptr,
                                              input int                  nreq);
    logic              found;
    logic [PICK_W-1:0] idx;
    int                cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ_MAX; k++) begin
      cand = (int'(ptr) + k) % nreq;
      if (!found && (k <= nreq) && valid[cand[PICK_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[PICK_W-1:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter.
// The pointer register lives in the parent; this block only searches
// i_valid starting one past i_ptr.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_valid,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_grant_idx
);

  logic [NREQ_MAX-1:0] valid_ext;
  logic [PICK_W:0]     pick;

  // Widen to the helper's fixed size, search, then narrow the index back.
  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = i_valid;
    pick                  = rr_pick(valid_ext, PICK_W'(i_ptr), NREQ);
    o_found               = pick[PICK_W];
    o_grant_idx           = IDX_W'(pick[PICK_W-1:0]);
  end

endmodule

// File: rtl/wallace_tree_multiplier.sv
// Combinational 8x8 unsigned Wallace-tree multiplier.
// Eight partial-product rows are reduced by layers of 3:2 carry-save
// compressors down to two rows, which one final adder sums.
// Every row is kept at full product width.
// The dropped carry-out of each layer is harmless because the true
// product always fits in 16 bits.
module wallace_tree_multiplier (
  input  logic [7:0]  i_m,
  input  logic [7:0]  i_q,
  output logic [15:0] o_p
);

  logic [15:0] pp [8];
  logic [15:0] s1a, c1a, s1b, c1b;
  logic [15:0] s2a, c2a, s2b, c2b;
  logic [15:0] s3, c3;
  logic [15:0] s4, c4;

  function automatic logic [15:0] csa_sum(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [15:0] c);
    return a ^ b ^ c;
  endfunction

  function automatic logic [15:0] csa_carry(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic [15:0] c);
    logic [15:0] maj;
    maj = (a & b) | (a & c) | (b & c);
    return maj << 1;
  endfunction

  // Partial products: row i is the multiplicand shifted by i, gated by q[i].
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = i_q[i] ? (16'(i_m) << i) : '0;
    end
  end

  // Reduction tree: 8 -> 6 -> 4 -> 3 -> 2 rows, then a carry-propagate add.
  always_comb begin
    s1a = csa_sum  (pp[0], pp[1], pp[2]);
    c1a = csa_carry(pp[0], pp[1], pp[2]);
    s1b = csa_sum  (pp[3], pp[4], pp[5]);
    c1b = csa_carry(pp[3], pp[4], pp[5]);

    s2a = csa_sum  (s1a, c1a, s1b);
    c2a = csa_carry(s1a, c1a, s1b);
    s2b = csa_sum  (c1b, pp[6], pp[7]);
    c2b = csa_carry(c1b, pp[6], pp[7]);

    s3  = csa_sum  (s2a, c2a, s2b);
    c3  = csa_carry(s2a, c2a, s2b);

    s4  = csa_sum  (s3, c3, c2b);
    c4  = csa_carry(s3, c3, c2b);

    o_p = s4 + c4;
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler that shares one combinational multiplier among
// NREQ requesters.
// Pipeline:
//   S1 - operand registers plus requester id; these drive the multiplier.
//   S2 - result register, presented as the response.
//
// Handshake semantics (all ports):
//   A transfer happens on a rising edge where valid & ready are both high.
//   Requesters must hold their operands stable while valid & ~ready.
//   A requester may drop valid before it sees ready; nothing happens then.
//   Ready never depends on anything registered downstream other than the
//   S1/S2 occupancy, so there is no combinational valid->ready->valid loop.
module mult_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter  int NREQ  = MS_NREQ,
  parameter  int WIDTH = MS_WIDTH,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_m,
  input  logic [NREQ*WIDTH-1:0] i_req_q,
  output logic [NREQ-1:0]       o_req_ready,
  output logic [WIDTH-1:0]      o_mul_m,
  output logic [WIDTH-1:0]      o_mul_q,
  input  logic [2*WIDTH-1:0]    i_mul_p,
  output logic                  o_rsp_valid,
  output logic [IDX_W-1:0]      o_rsp_id,
  output logic [2*WIDTH-1:0]    o_rsp_p,
  input  logic                  i_rsp_ready,
  output logic                  o_busy
);

  // Operand-stage entry sized for this instance.
  typedef struct packed {
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] q;
    logic [IDX_W-1:0] id;
  } s1_t;

  s1_t              s1;
  logic             s1_valid;
  logic [IDX_W-1:0] ptr;

  logic             found;
  logic [IDX_W-1:0] grant_idx;
  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  s1_t              accept_op;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .i_valid    (i_req_valid),
    .i_ptr      (ptr),
    .o_found    (found),
    .o_grant_idx(grant_idx)
  );

  // Stage-advance conditions and the grant.
  // Ready is also held low while reset is asserted, so every output reads
  // 0 during reset.
  always_comb begin
    s2_adv       = ~o_rsp_valid | i_rsp_ready;
    s1_adv       = ~s1_valid | s2_adv;
    accept       = found & s1_adv & i_rst_n;
    o_req_ready  = accept ? (NREQ'(1'b1) << grant_idx) : '0;
    accept_op.m  = i_req_m[grant_idx*WIDTH +: WIDTH];
    accept_op.q  = i_req_q[grant_idx*WIDTH +: WIDTH];
    accept_op.id = grant_idx;
  end

  // S1: capture the granted operands and advance the round-robin pointer.
  // The pointer moves only on an accept, so an idle requester cannot
  // stall the rotation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1       <= '0;
      s1_valid <= 1'b0;
      ptr      <= IDX_W'(NREQ - 1);
    end else if (accept) begin
      s1       <= accept_op;
      s1_valid <= 1'b1;
      ptr      <= grant_idx;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: latch the multiplier output whenever the result register may advance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid <= 1'b0;
      o_rsp_p     <= '0;
      o_rsp_id    <= '0;
    end else if (s2_adv) begin
      o_rsp_valid <= s1_valid;
      o_rsp_p     <= i_mul_p;
      o_rsp_id    <= s1.id;
    end
  end

  // Operand registers drive the external multiplier directly.
  always_comb begin
    o_mul_m = s1.m;
    o_mul_q = s1.q;
    o_busy  = s1_valid | o_rsp_valid;
  end

endmodule
